sseg_mux_driver: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for common-anode multi-digit displays. Takes a packed vector of DIGITS hex nibbles plus per-digit decimal-point and blank masks. Scans one digit per refresh slot, driving one anode and the shared segment/DP lines. Adds leading-zero suppression and output polarity selection. Sits between the hex-valued datapath (counters, debug registers) and the board's anode/segment pins.

---
 rtl/sseg_mux_driver.sv | 136 +++++++++++++
 tb/tb_sseg_mux_driver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sseg_mux_driver.sv
// Time-multiplexed seven-segment driver for multi-digit displays.
// Scans one digit per refresh slot, with per-digit blank/DP masks,
// leading-zero suppression and selectable output polarity.
module sseg_mux_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   hex,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_suppress,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic                  digit_strobe
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    // Masks XORed onto the logical active-low values to get pin polarity.
    localparam logic [DIGITS-1:0] AN_POL  = ACTIVE_LOW ? '0 : '1;
    localparam logic [6:0]        SEG_POL = ACTIVE_LOW ? '0 : '1;
    localparam logic              DP_POL  = ACTIVE_LOW ? 1'b0 : 1'b1;

    logic [CW-1:0]     r_div_cnt;
    logic [IW-1:0]     r_idx;
    logic [DIGITS-1:0] r_an;
    logic [6:0]        r_seg;
    logic              r_dp_out;
    logic              r_digit_strobe;

    logic              w_tc;
    logic              w_run_zero;
    logic [DIGITS-1:0] w_dark_mask;
    logic [3:0]        w_nib;
    logic              w_sel_dark;
    logic              w_sel_dp;
    logic [DIGITS-1:0] w_an_l;
    logic [6:0]        w_dec_l;
    logic [6:0]        w_seg_l;
    logic              w_dp_l;

    assign w_tc = (r_div_cnt == DIV_LAST);

    // Per-digit dark mask: blanked, or a suppressed leading zero.
    // Walks from the most significant digit down so w_run_zero holds
    // "this nibble and every one above it are zero".
    always_comb begin
        w_run_zero  = 1'b1;
        w_dark_mask = '0;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            w_run_zero = w_run_zero & (hex[4*(DIGITS-1-j) +: 4] == 4'h0);
            w_dark_mask[DIGITS-1-j] = blank[DIGITS-1-j]
                                    | (lz_suppress & w_run_zero & (j != DIGITS-1));
        end
    end

    // Select the scanned digit's nibble, darkness and DP; build logical anodes.
    always_comb begin
        w_nib      = 4'h0;
        w_sel_dark = 1'b1;
        w_sel_dp   = 1'b0;
        w_an_l     = '1;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            if (r_idx == IW'(j)) begin
                w_nib      = hex[4*j +: 4];
                w_sel_dark = w_dark_mask[j];
                w_sel_dp   = dp[j];
                w_an_l[j]  = w_dark_mask[j];
            end
        end
    end

    // Hex to active-low segment pattern {g,f,e,d,c,b,a}.
    always_comb begin
        unique case (w_nib)
            4'h0: w_dec_l = 7'h40;
            4'h1: w_dec_l = 7'h79;
            4'h2: w_dec_l = 7'h24;
            4'h3: w_dec_l = 7'h30;
            4'h4: w_dec_l = 7'h19;
            4'h5: w_dec_l = 7'h12;
            4'h6: w_dec_l = 7'h02;
            4'h7: w_dec_l = 7'h78;
            4'h8: w_dec_l = 7'h00;
            4'h9: w_dec_l = 7'h10;
            4'hA: w_dec_l = 7'h08;
            4'hB: w_dec_l = 7'h03;
            4'hC: w_dec_l = 7'h46;
            4'hD: w_dec_l = 7'h21;
            4'hE: w_dec_l = 7'h06;
            default: w_dec_l = 7'h0E;
        endcase
    end

    // Dark digits force all segments and the DP off.
    always_comb begin
        w_seg_l = w_sel_dark ? 7'h7F : w_dec_l;
        w_dp_l  = w_sel_dark ? 1'b1  : ~w_sel_dp;
    end

    // Prescaler, scan index and registered pin outputs.
    // The strobe marks the cycle in which a freshly advanced index is first
    // on the anodes, i.e. the output registered while div_cnt was 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt      <= '0;
            r_idx          <= '0;
            r_digit_strobe <= 1'b0;
            r_an           <= '1 ^ AN_POL;
            r_seg          <= 7'h7F ^ SEG_POL;
            r_dp_out       <= 1'b1 ^ DP_POL;
        end else begin
            r_div_cnt <= w_tc ? '0 : r_div_cnt + 1'b1;
            if (w_tc && (DIGITS > 1)) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
            r_digit_strobe <= (r_div_cnt == '0);
            r_an           <= w_an_l ^ AN_POL;
            r_seg          <= w_seg_l ^ SEG_POL;
            r_dp_out       <= w_dp_l ^ DP_POL;
        end
    end

    assign an           = r_an;
    assign seg          = r_seg;
    assign dp_out       = r_dp_out;
    assign digit_strobe = r_digit_strobe;

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Bench for sseg_mux_driver: three instances (4-digit active-low,
// 4-digit active-high, 1-digit) driven from shared inputs and compared
// every cycle against a slot-arithmetic reference model.
module tb_sseg_mux_driver;

    localparam logic [6:0] DEC [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz;

    logic [3:0] an_m, an_p;
    logic [6:0] seg_m, seg_p, seg_o;
    logic [0:0] an_o;
    logic       dp_m, dp_p, dp_o;
    logic       stb_m, stb_p, stb_o;

    int vectors = 0;
    int miscompares = 0;
    int n = 0;

    always #5 clk = ~clk;

    sseg_mux_driver #(.DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) u_main (
        .clk(clk), .reset(reset), .hex(hex), .dp(dp), .blank(blank),
        .lz_suppress(lz), .an(an_m), .seg(seg_m), .dp_out(dp_m),
        .digit_strobe(stb_m)
    );

    sseg_mux_driver #(.DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) u_pos (
        .clk(clk), .reset(reset), .hex(hex), .dp(dp), .blank(blank),
        .lz_suppress(lz), .an(an_p), .seg(seg_p), .dp_out(dp_p),
        .digit_strobe(stb_p)
    );

    sseg_mux_driver #(.DIGITS(1), .REFRESH_DIV(2), .ACTIVE_LOW(1'b1)) u_one (
        .clk(clk), .reset(reset), .hex(hex[3:0]), .dp(dp[0:0]),
        .blank(blank[0:0]), .lz_suppress(lz), .an(an_o), .seg(seg_o),
        .dp_out(dp_o), .digit_strobe(stb_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    // Edge nn (1-based since reset release) shows digit ((nn-1)/r) mod d,
    // using the inputs present at that edge; values are logical active-low.
    function automatic void model(input int nn, input int r, input int d,
                                  input logic [31:0] h, input logic [7:0] dpv,
                                  input logic [7:0] blv, input logic lzv,
                                  output logic [7:0] an_l, output logic [6:0] sg_l,
                                  output logic dp_l, output logic stb);
        int  k;
        logic dark;
        k    = ((nn - 1) / r) % d;
        dark = blv[k] || (lzv && k != 0 && (h >> (4 * k)) == 32'h0);
        an_l = 8'hFF;
        sg_l = 7'h7F;
        dp_l = 1'b1;
        if (!dark) begin
            an_l[k] = 1'b0;
            sg_l    = DEC[int'((h >> (4 * k)) & 32'hF)];
            dp_l    = ~dpv[k];
        end
        stb = (((nn - 1) % r) == 0);
    endfunction

    task automatic check_all();
        logic [7:0] a;
        logic [6:0] s;
        logic       d, st;
        model(n, 4, 4, {16'h0, hex}, {4'h0, dp}, {4'h0, blank}, lz, a, s, d, st);
        chk("main_an",  {28'h0, an_m},  {28'h0, a[3:0]});
        chk("main_seg", {25'h0, seg_m}, {25'h0, s});
        chk("main_dp",  {31'h0, dp_m},  {31'h0, d});
        chk("main_stb", {31'h0, stb_m}, {31'h0, st});
        chk("pos_an",   {28'h0, an_p},  {28'h0, ~a[3:0]});
        chk("pos_seg",  {25'h0, seg_p}, {25'h0, ~s});
        chk("pos_dp",   {31'h0, dp_p},  {31'h0, ~d});
        chk("pos_stb",  {31'h0, stb_p}, {31'h0, st});
        model(n, 2, 1, {28'h0, hex[3:0]}, {7'h0, dp[0]}, {7'h0, blank[0]}, lz, a, s, d, st);
        chk("one_an",   {31'h0, an_o},  {31'h0, a[0]});
        chk("one_seg",  {25'h0, seg_o}, {25'h0, s});
        chk("one_dp",   {31'h0, dp_o},  {31'h0, d});
        chk("one_stb",  {31'h0, stb_o}, {31'h0, st});
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        #1;
        check_all();
    endtask

    task automatic check_dark(input string tag);
        chk({tag, "_an_m"},  {28'h0, an_m},  32'hF);
        chk({tag, "_seg_m"}, {25'h0, seg_m}, 32'h7F);
        chk({tag, "_dp_m"},  {31'h0, dp_m},  32'h1);
        chk({tag, "_stb_m"}, {31'h0, stb_m}, 32'h0);
        chk({tag, "_an_p"},  {28'h0, an_p},  32'h0);
        chk({tag, "_seg_p"}, {25'h0, seg_p}, 32'h0);
        chk({tag, "_dp_p"},  {31'h0, dp_p},  32'h0);
        chk({tag, "_an_o"},  {31'h0, an_o},  32'h1);
        chk({tag, "_seg_o"}, {25'h0, seg_o}, 32'h7F);
    endtask

    initial begin
        int hold;
        reset = 1'b1;
        hex   = 16'h1234;
        dp    = 4'h0;
        blank = 4'h0;
        lz    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_dark("reset");
        reset = 1'b0;
        n = 0;

        // Basic scan of 1234: digit 0 (value 4) first.
        step();
        chk("first_an", {28'h0, an_m}, 32'hE);
        chk("first_seg", {25'h0, seg_m}, 32'h19);
        chk("first_stb", {31'h0, stb_m}, 32'h1);
        repeat (15) step();

        // Every nibble value through the single-digit instance.
        for (int v = 0; v < 16; v++) begin
            hex[3:0] = 4'(v);
            repeat (2) step();
        end

        // Leading-zero suppression.
        hex = 16'h0040;
        lz  = 1'b1;
        repeat (16) step();
        hex = 16'h0000;
        repeat (16) step();

        // Blank and DP masks.
        lz    = 1'b0;
        hex   = 16'h8888;
        blank = 4'b0101;
        dp    = 4'b1010;
        repeat (16) step();

        // Reset asserted mid-slot 2.
        for (int i = 0; i < 20; i++) begin
            if (((n - 1) / 4) % 4 == 2 && ((n - 1) % 4) == 1) break;
            step();
        end
        #3 reset = 1'b1;
        #1 check_dark("midrst");
        @(posedge clk);
        #1 check_dark("midrst_hold");
        hex   = 16'h0001;
        blank = 4'h0;
        dp    = 4'h0;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("restart_an_m",  {28'h0, an_m},  32'hE);
            chk("restart_seg_m", {25'h0, seg_m}, 32'h79);
            chk("restart_an_p",  {28'h0, an_p},  32'h1);
            chk("restart_seg_p", {25'h0, seg_p}, 32'h06);
        end
        repeat (4) step();

        // Randomised inputs changing at arbitrary points within slots.
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 3))
                    0: hex = 16'($urandom);
                    1: hex = 16'($urandom) & 16'h00FF;
                    2: hex = 16'($urandom) & 16'h000F;
                    default: hex = 16'h0000;
                endcase
                dp    = 4'($urandom);
                blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                lz    = 1'($urandom);
                hold  = $urandom_range(1, 6);
            end
            hold--;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
